// File: rtl/rps_pkg.sv
// Shared types and helpers for the rock-paper-scissors match judge.
// Gestures are one-hot vectors; the win rule works for any odd gesture count.
package rps_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_JUDGE   = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_P1   = 2'd1,
    RES_P2   = 2'd2,
    RES_TIE  = 2'd3
  } result_e;

  localparam int MAX_GESTURES = 32;

  function automatic logic is_onehot(input logic [MAX_GESTURES-1:0] v);
    logic [MAX_GESTURES-1:0] one;
    one = {{(MAX_GESTURES-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

  function automatic int onehot_index(input logic [MAX_GESTURES-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_GESTURES; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Gesture i beats j when (i - j) mod n falls in the lower half of the non-zero residues.
  function automatic logic beats(input int i, input int j, input int n);
    int d;
    d = ((i - j) % n + n) % n;
    return (d >= 1) && (d <= (n - 1) / 2);
  endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational round judge: two one-hot gestures in, one-hot result out.
module rps_round_judge
  import rps_pkg::*;
#(
  parameter int NUM_GESTURES = 3
) (
  input  logic [NUM_GESTURES-1:0] p1_gesture_i,
  input  logic [NUM_GESTURES-1:0] p2_gesture_i,
  output logic                    p1wins_o,
  output logic                    p2wins_o,
  output logic                    tied_o
);

  logic [MAX_GESTURES-1:0] p1_ext;
  logic [MAX_GESTURES-1:0] p2_ext;
  int                      p1_idx;
  int                      p2_idx;

  always_comb begin
    p1_ext = '0;
    p2_ext = '0;
    p1_ext[NUM_GESTURES-1:0] = p1_gesture_i;
    p2_ext[NUM_GESTURES-1:0] = p2_gesture_i;
    p1_idx   = onehot_index(p1_ext);
    p2_idx   = onehot_index(p2_ext);
    tied_o   = (p1_idx == p2_idx);
    p1wins_o = beats(p1_idx, p2_idx, NUM_GESTURES);
    p2wins_o = beats(p2_idx, p1_idx, NUM_GESTURES);
  end

endmodule

// File: rtl/rps_match_judge.sv
// Match controller: collects both players' gestures, judges each round,
// keeps scores and declares the match winner at WIN_TARGET round wins.
module rps_match_judge
  import rps_pkg::*;
#(
  parameter int NUM_GESTURES = 3,
  parameter int WIN_TARGET   = 2,
  parameter int SCORE_W      = $clog2(WIN_TARGET + 1),
  parameter int ROUND_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    new_match,
  input  logic                    p1_valid,
  input  logic [NUM_GESTURES-1:0] p1_gesture,
  output logic                    p1_ready,
  input  logic                    p2_valid,
  input  logic [NUM_GESTURES-1:0] p2_gesture,
  output logic                    p2_ready,
  output logic                    round_valid,
  output logic                    p1wins,
  output logic                    p2wins,
  output logic                    tied,
  output logic [SCORE_W-1:0]      p1_score,
  output logic [SCORE_W-1:0]      p2_score,
  output logic [ROUND_W-1:0]      round_count,
  output logic                    match_over,
  output logic                    match_winner,
  output logic                    bad_move
);

  state_e                  state_q, state_d;
  logic                    p1_held_q, p1_held_d, p2_held_q, p2_held_d;
  logic [NUM_GESTURES-1:0] p1_gest_q, p1_gest_d, p2_gest_q, p2_gest_d;
  logic                    bad_q, bad_d;
  logic                    round_valid_q, round_valid_d;
  result_e                 result_q, result_d;
  logic [SCORE_W-1:0]      p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [ROUND_W-1:0]      round_cnt_q, round_cnt_d;
  logic                    winner_q, winner_d;

  logic                    j_p1wins, j_p2wins, j_tied;
  logic [MAX_GESTURES-1:0] p1_ext, p2_ext;
  logic                    p1_offer, p2_offer, p1_oh, p2_oh;
  logic [SCORE_W-1:0]      p1_score_inc, p2_score_inc;
  logic                    p1_reach, p2_reach;

  rps_round_judge #(
    .NUM_GESTURES(NUM_GESTURES)
  ) u_judge (
    .p1_gesture_i(p1_gest_q),
    .p2_gesture_i(p2_gest_q),
    .p1wins_o    (j_p1wins),
    .p2wins_o    (j_p2wins),
    .tied_o      (j_tied)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_match) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT: if (p1_held_d && p2_held_d) state_d = ST_JUDGE;
        ST_JUDGE:   state_d = (p1_reach || p2_reach) ? ST_DONE : ST_COLLECT;
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_COLLECT;
      endcase
    end
  end

  always_comb begin
    p1_ready   = (state_q == ST_COLLECT) && !p1_held_q;
    p2_ready   = (state_q == ST_COLLECT) && !p2_held_q;
    match_over = (state_q == ST_DONE);
  end

  // Offers made alongside new_match are dropped entirely, including bad_move.
  always_comb begin
    p1_ext = '0;
    p2_ext = '0;
    p1_ext[NUM_GESTURES-1:0] = p1_gesture;
    p2_ext[NUM_GESTURES-1:0] = p2_gesture;
    p1_oh        = is_onehot(p1_ext);
    p2_oh        = is_onehot(p2_ext);
    p1_offer     = p1_valid && p1_ready && !new_match;
    p2_offer     = p2_valid && p2_ready && !new_match;
    p1_score_inc = p1_score_q + SCORE_W'(1);
    p2_score_inc = p2_score_q + SCORE_W'(1);
    p1_reach     = j_p1wins && (p1_score_inc == SCORE_W'(WIN_TARGET));
    p2_reach     = j_p2wins && (p2_score_inc == SCORE_W'(WIN_TARGET));

    p1_held_d     = p1_held_q || (p1_offer && p1_oh);
    p2_held_d     = p2_held_q || (p2_offer && p2_oh);
    p1_gest_d     = (p1_offer && p1_oh) ? p1_gesture : p1_gest_q;
    p2_gest_d     = (p2_offer && p2_oh) ? p2_gesture : p2_gest_q;
    bad_d         = (p1_offer && !p1_oh) || (p2_offer && !p2_oh);
    round_valid_d = 1'b0;
    result_d      = result_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    round_cnt_d   = round_cnt_q;
    winner_d      = winner_q;

    if (new_match) begin
      p1_held_d   = 1'b0;
      p2_held_d   = 1'b0;
      result_d    = RES_NONE;
      p1_score_d  = '0;
      p2_score_d  = '0;
      round_cnt_d = '0;
      winner_d    = 1'b0;
    end else if (state_q == ST_JUDGE) begin
      p1_held_d     = 1'b0;
      p2_held_d     = 1'b0;
      round_valid_d = 1'b1;
      if (j_p1wins) begin
        result_d   = RES_P1;
        p1_score_d = p1_score_inc;
      end else if (j_p2wins) begin
        result_d   = RES_P2;
        p2_score_d = p2_score_inc;
      end else begin
        result_d   = RES_TIE;
      end
      if (round_cnt_q != '1) round_cnt_d = round_cnt_q + ROUND_W'(1);
      if (p1_reach || p2_reach) winner_d = p2_reach;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_held_q     <= 1'b0;
      p2_held_q     <= 1'b0;
      p1_gest_q     <= '0;
      p2_gest_q     <= '0;
      bad_q         <= 1'b0;
      round_valid_q <= 1'b0;
      result_q      <= RES_NONE;
      p1_score_q    <= '0;
      p2_score_q    <= '0;
      round_cnt_q   <= '0;
      winner_q      <= 1'b0;
    end else begin
      p1_held_q     <= p1_held_d;
      p2_held_q     <= p2_held_d;
      p1_gest_q     <= p1_gest_d;
      p2_gest_q     <= p2_gest_d;
      bad_q         <= bad_d;
      round_valid_q <= round_valid_d;
      result_q      <= result_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      round_cnt_q   <= round_cnt_d;
      winner_q      <= winner_d;
    end
  end

  assign round_valid  = round_valid_q;
  assign p1wins       = (result_q == RES_P1);
  assign p2wins       = (result_q == RES_P2);
  assign tied         = (result_q == RES_TIE);
  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign round_count  = round_cnt_q;
  assign match_winner = winner_q;
  assign bad_move     = bad_q;

endmodule

// File: tb/tb_rps_match_judge.sv
// Directed bench for rps_match_judge: a default 3-gesture instance and a
// 5-gesture instance sharing clock and reset.
module tb_rps_match_judge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_match, p1_valid, p2_valid;
  logic [2:0] p1_gesture, p2_gesture;
  logic       p1_ready, p2_ready, round_valid, p1wins, p2wins, tied;
  logic [1:0] p1_score, p2_score;
  logic [7:0] round_count;
  logic       match_over, match_winner, bad_move;

  logic       f_new_match, f_p1_valid, f_p2_valid;
  logic [4:0] f_p1_gesture, f_p2_gesture;
  logic       f_p1_ready, f_p2_ready, f_round_valid, f_p1wins, f_p2wins, f_tied;
  logic [1:0] f_p1_score, f_p2_score;
  logic [7:0] f_round_count;
  logic       f_match_over, f_match_winner, f_bad_move;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rps_match_judge dut (
    .clk(clk), .rst_n(rst_n), .new_match(new_match),
    .p1_valid(p1_valid), .p1_gesture(p1_gesture), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_gesture(p2_gesture), .p2_ready(p2_ready),
    .round_valid(round_valid), .p1wins(p1wins), .p2wins(p2wins), .tied(tied),
    .p1_score(p1_score), .p2_score(p2_score), .round_count(round_count),
    .match_over(match_over), .match_winner(match_winner), .bad_move(bad_move)
  );

  rps_match_judge #(.NUM_GESTURES(5), .WIN_TARGET(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .new_match(f_new_match),
    .p1_valid(f_p1_valid), .p1_gesture(f_p1_gesture), .p1_ready(f_p1_ready),
    .p2_valid(f_p2_valid), .p2_gesture(f_p2_gesture), .p2_ready(f_p2_ready),
    .round_valid(f_round_valid), .p1wins(f_p1wins), .p2wins(f_p2wins), .tied(f_tied),
    .p1_score(f_p1_score), .p2_score(f_p2_score), .round_count(f_round_count),
    .match_over(f_match_over), .match_winner(f_match_winner), .bad_move(f_bad_move)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic nm, input logic v1, input logic [2:0] g1,
                               input logic v2, input logic [2:0] g2);
    @(negedge clk);
    new_match  = nm;
    p1_valid   = v1;
    p1_gesture = g1;
    p2_valid   = v2;
    p2_gesture = g2;
  endtask

  task automatic applyFive(input logic v1, input logic [4:0] g1, input logic v2, input logic [4:0] g2);
    @(negedge clk);
    f_p1_valid   = v1;
    f_p1_gesture = g1;
    f_p2_valid   = v2;
    f_p2_gesture = g2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    new_match = 0; p1_valid = 0; p2_valid = 0; p1_gesture = 0; p2_gesture = 0;
    f_new_match = 0; f_p1_valid = 0; f_p2_valid = 0; f_p1_gesture = 0; f_p2_gesture = 0;

    #12;
    checkOutput("rst_round_valid", 32'(round_valid), 0);
    checkOutput("rst_p1_score", 32'(p1_score), 0);
    checkOutput("rst_round_count", 32'(round_count), 0);
    checkOutput("rst_match_over", 32'(match_over), 0);
    checkOutput("rst_bad_move", 32'(bad_move), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_p1_ready", 32'(p1_ready), 1);
    checkOutput("rst_p2_ready", 32'(p2_ready), 1);

    // Round 1: rock vs scissors, both accepted at the same edge
    applyStimulus(0, 1, 3'b001, 1, 3'b100);
    tick();
    checkOutput("r1_no_early_valid", 32'(round_valid), 0);
    checkOutput("r1_p1_held", 32'(p1_ready), 0);
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    tick();
    checkOutput("r1_round_valid", 32'(round_valid), 1);
    checkOutput("r1_p1wins", 32'(p1wins), 1);
    checkOutput("r1_p2wins", 32'(p2wins), 0);
    checkOutput("r1_tied", 32'(tied), 0);
    checkOutput("r1_p1_score", 32'(p1_score), 1);
    checkOutput("r1_p2_score", 32'(p2_score), 0);
    checkOutput("r1_round_count", 32'(round_count), 1);
    checkOutput("r1_match_over", 32'(match_over), 0);
    checkOutput("r1_p1_ready", 32'(p1_ready), 1);

    // Round 2: same moves win the match for player 1
    applyStimulus(0, 1, 3'b001, 1, 3'b100);
    tick();
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    tick();
    checkOutput("r2_round_valid", 32'(round_valid), 1);
    checkOutput("r2_match_over", 32'(match_over), 1);
    checkOutput("r2_match_winner", 32'(match_winner), 0);
    checkOutput("r2_p1_score", 32'(p1_score), 2);
    checkOutput("r2_round_count", 32'(round_count), 2);
    checkOutput("r2_p1_ready", 32'(p1_ready), 0);
    checkOutput("r2_p2_ready", 32'(p2_ready), 0);
    tick();
    checkOutput("done_pulse_end", 32'(round_valid), 0);
    checkOutput("done_hold", 32'(match_over), 1);
    checkOutput("done_hold_p1wins", 32'(p1wins), 1);

    // new_match together with a gesture: match clears, gesture not taken
    applyStimulus(1, 1, 3'b010, 0, 3'b000);
    tick();
    checkOutput("nm_p1_score", 32'(p1_score), 0);
    checkOutput("nm_round_count", 32'(round_count), 0);
    checkOutput("nm_match_over", 32'(match_over), 0);
    checkOutput("nm_p1wins", 32'(p1wins), 0);
    checkOutput("nm_p1_not_held", 32'(p1_ready), 1);
    applyStimulus(0, 1, 3'b010, 0, 3'b000);
    tick();
    checkOutput("nm_next_accept", 32'(p1_ready), 0);

    // P1 paper waits while P2 is slow; offers while not ready are ignored
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 3'b011, 0, 3'b000);
      tick();
      checkOutput("wait_p1_ready", 32'(p1_ready), 0);
      checkOutput("wait_no_bad", 32'(bad_move), 0);
      checkOutput("wait_no_round", 32'(round_valid), 0);
    end
    applyStimulus(0, 0, 3'b000, 1, 3'b010);
    tick();
    checkOutput("tie_latency", 32'(round_valid), 0);
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    tick();
    checkOutput("tie_round_valid", 32'(round_valid), 1);
    checkOutput("tie_tied", 32'(tied), 1);
    checkOutput("tie_p1wins", 32'(p1wins), 0);
    checkOutput("tie_p1_score", 32'(p1_score), 0);
    checkOutput("tie_p2_score", 32'(p2_score), 0);
    checkOutput("tie_round_count", 32'(round_count), 1);

    // Non-one-hot offer rejected with a single bad_move pulse
    applyStimulus(0, 1, 3'b011, 0, 3'b000);
    tick();
    checkOutput("bad_pulse", 32'(bad_move), 1);
    checkOutput("bad_p1_ready", 32'(p1_ready), 1);
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    tick();
    checkOutput("bad_pulse_end", 32'(bad_move), 0);
    checkOutput("bad_no_round", 32'(round_valid), 0);
    checkOutput("bad_p2_ready", 32'(p2_ready), 1);
    applyStimulus(0, 1, 3'b000, 1, 3'b111);
    tick();
    checkOutput("bad_both_pulse", 32'(bad_move), 1);
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    tick();
    checkOutput("bad_both_end", 32'(bad_move), 0);
    checkOutput("bad_both_not_held", 32'(p1_ready), 1);

    // Asynchronous reset with player 1 holding a gesture
    applyStimulus(0, 1, 3'b001, 0, 3'b000);
    tick();
    checkOutput("ar_held", 32'(p1_ready), 0);
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_p1_ready", 32'(p1_ready), 1);
    checkOutput("ar_round_count", 32'(round_count), 0);
    checkOutput("ar_tied", 32'(tied), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh rounds after reset: paper beats rock, then rock beats scissors
    applyStimulus(0, 1, 3'b010, 1, 3'b001);
    tick();
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    tick();
    checkOutput("fr_round_valid", 32'(round_valid), 1);
    checkOutput("fr_p1wins", 32'(p1wins), 1);
    checkOutput("fr_p1_score", 32'(p1_score), 1);
    checkOutput("fr_round_count", 32'(round_count), 1);
    applyStimulus(0, 1, 3'b100, 1, 3'b001);
    tick();
    applyStimulus(0, 0, 3'b000, 0, 3'b000);
    tick();
    checkOutput("fr2_p2wins", 32'(p2wins), 1);
    checkOutput("fr2_p1wins", 32'(p1wins), 0);
    checkOutput("fr2_p2_score", 32'(p2_score), 1);
    checkOutput("fr2_p1_score", 32'(p1_score), 1);
    checkOutput("fr2_round_count", 32'(round_count), 2);
    checkOutput("fr2_match_over", 32'(match_over), 0);

    // Five-gesture instance
    applyFive(1, 5'b01000, 1, 5'b00010);
    tick();
    applyFive(0, 5'b00000, 0, 5'b00000);
    tick();
    checkOutput("g5_3v1_valid", 32'(f_round_valid), 1);
    checkOutput("g5_3v1_p1wins", 32'(f_p1wins), 1);
    checkOutput("g5_3v1_p1_score", 32'(f_p1_score), 1);
    applyFive(1, 5'b00010, 1, 5'b10000);
    tick();
    applyFive(0, 5'b00000, 0, 5'b00000);
    tick();
    checkOutput("g5_1v4_p1wins", 32'(f_p1wins), 1);
    checkOutput("g5_1v4_p1_score", 32'(f_p1_score), 2);
    applyFive(1, 5'b00001, 1, 5'b00100);
    tick();
    applyFive(0, 5'b00000, 0, 5'b00000);
    tick();
    checkOutput("g5_0v2_p2wins", 32'(f_p2wins), 1);
    checkOutput("g5_0v2_p1wins", 32'(f_p1wins), 0);
    checkOutput("g5_0v2_p2_score", 32'(f_p2_score), 1);
    checkOutput("g5_round_count", 32'(f_round_count), 3);
    checkOutput("g5_match_over", 32'(f_match_over), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
